alu_op_issuer: RTL and testbench

Sequencing front-end for the datapath ALU. It accepts one instruction (with its two register operands) over a valid/ready request channel and decodes the opcode/funct into the ALU's 6-bit control code. It builds the ALU operand pair, holds the ALU inputs stable for a programmable settle window, and captures result, zero and overflow. It then returns them over a valid/ready response channel. It is the initiator side of the ALU control interface: it produces the control codes, and the ALU consumes them.

---
 rtl/alu_op_issuer.sv | 203 ++++++++++++++++++++
 tb/tb_alu_op_issuer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
// alu_op_issuer
//
// Sequencing front-end for the datapath ALU. One instruction at a time is
// accepted over a valid/ready request channel, decoded into the ALU's 6-bit
// control code, and its operand pair is presented to the ALU. The ALU inputs
// are held for a programmable settle window before the result is captured.
// The captured result, branch flag and overflow flag are then returned over a
// valid/ready response channel.
//
// Parameters
//   SETTLE_CYCLES    cycles the ALU inputs are held before capture (1..255)
//   COUNT_RESET_VAL  value op_count takes on reset (normally 0)
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/ready    request handshake; ready only while idle
//   req_instr          instruction word: opcode [31:26], funct [5:0], imm [15:0]
//   req_rs_val/rt_val  register operands, sampled at the accept edge only
//   alu_control/a/b    ALU control code and operands; zero outside ISSUE
//   alu_out/zero/ovf   ALU result, branch-condition flag, carry-out flag
//   rsp_valid/ready    response handshake
//   rsp_result         captured ALU result (0 for illegal instructions)
//   rsp_branch_taken   captured alu_zero, branch opcodes only
//   rsp_overflow       captured alu_overflow (0 for illegal instructions)
//   rsp_illegal        instruction was not decodable
//   op_count           completed responses, wraps silently
//
// state | meaning
// IDLE  | waiting for a request; req_ready=1, ALU inputs zero
// ISSUE | ALU inputs driven from latched decode; settle counter running
// RESP  | rsp_* valid and held until the consumer takes them

module alu_op_issuer #(
  parameter int unsigned SETTLE_CYCLES   = 1,
  parameter logic [15:0] COUNT_RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_instr,
  input  logic [31:0] req_rs_val,
  input  logic [31:0] req_rt_val,
  output logic [5:0]  alu_control,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_branch_taken,
  output logic        rsp_overflow,
  output logic        rsp_illegal,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t      state;
  logic [7:0]  settle_cnt;
  logic        branch_q;
  logic        illegal_q;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [5:0]  dec_ctrl;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic        dec_branch;
  logic        dec_illegal;

  // rs/rt/rd/shamt fields are carried by the register values, not decoded here
  logic        unused_instr_bits;
  assign unused_instr_bits = ^req_instr[25:16];

  assign opcode = req_instr[31:26];
  assign funct  = req_instr[5:0];
  assign imm    = req_instr[15:0];

  // Illegal instructions leave control and both operands at zero so the ALU
  // sees an inert input pair during ISSUE.
  always_comb begin
    dec_ctrl    = 6'd0;
    dec_a       = 32'd0;
    dec_b       = 32'd0;
    dec_branch  = 1'b0;
    dec_illegal = 1'b1;
    case (opcode)
      6'd0: begin
        if (funct inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42}) begin
          dec_ctrl    = funct;
          dec_a       = req_rs_val;
          dec_b       = req_rt_val;
          dec_illegal = 1'b0;
        end
      end
      6'd8, 6'd10: begin
        dec_ctrl    = opcode;
        dec_a       = req_rs_val;
        dec_b       = {{16{imm[15]}}, imm};
        dec_illegal = 1'b0;
      end
      6'd12, 6'd13, 6'd14: begin
        dec_ctrl    = opcode;
        dec_a       = req_rs_val;
        dec_b       = {16'd0, imm};
        dec_illegal = 1'b0;
      end
      6'd4, 6'd5: begin
        dec_ctrl    = opcode;
        dec_a       = req_rs_val;
        dec_b       = req_rt_val;
        dec_branch  = 1'b1;
        dec_illegal = 1'b0;
      end
      6'd1: begin
        dec_ctrl    = 6'd1;
        dec_a       = req_rs_val;
        dec_b       = 32'd0;
        dec_branch  = 1'b1;
        dec_illegal = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // The alu_* outputs are themselves the latched decode registers: loaded at
  // accept, cleared at capture, so they are zero in every state but ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      req_ready        <= 1'b1;
      rsp_valid        <= 1'b0;
      alu_control      <= 6'd0;
      alu_a            <= 32'd0;
      alu_b            <= 32'd0;
      settle_cnt       <= 8'd0;
      branch_q         <= 1'b0;
      illegal_q        <= 1'b0;
      rsp_result       <= 32'd0;
      rsp_branch_taken <= 1'b0;
      rsp_overflow     <= 1'b0;
      rsp_illegal      <= 1'b0;
      op_count         <= COUNT_RESET_VAL;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            alu_control <= dec_ctrl;
            alu_a       <= dec_a;
            alu_b       <= dec_b;
            branch_q    <= dec_branch;
            illegal_q   <= dec_illegal;
            settle_cnt  <= SETTLE_LOAD;
            req_ready   <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (settle_cnt == 8'd0) begin
            rsp_result       <= illegal_q ? 32'd0 : alu_out;
            rsp_branch_taken <= branch_q & alu_zero;
            rsp_overflow     <= ~illegal_q & alu_overflow;
            rsp_illegal      <= illegal_q;
            rsp_valid        <= 1'b1;
            alu_control      <= 6'd0;
            alu_a            <= 32'd0;
            alu_b            <= 32'd0;
            state            <= RESP;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        RESP: begin
          // req_ready rises one edge after the response handshake, so a
          // request can never be accepted in the same cycle.
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            op_count  <= op_count + 16'd1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
module tb_alu_op_issuer;

  localparam int ND = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid        [ND];
  logic        req_ready        [ND];
  logic [31:0] req_instr        [ND];
  logic [31:0] req_rs_val       [ND];
  logic [31:0] req_rt_val       [ND];
  logic [5:0]  alu_control      [ND];
  logic [31:0] alu_a            [ND];
  logic [31:0] alu_b            [ND];
  logic [31:0] alu_out          [ND];
  logic        alu_zero         [ND];
  logic        alu_overflow     [ND];
  logic        rsp_valid        [ND];
  logic        rsp_ready        [ND];
  logic [31:0] rsp_result       [ND];
  logic        rsp_branch_taken [ND];
  logic        rsp_overflow     [ND];
  logic        rsp_illegal      [ND];
  logic [15:0] op_count         [ND];

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] exp_count [ND];

  // Behavioural ALU: returns {overflow, zero, result}. Unknown control codes
  // (including 0) give a loud non-zero pattern so masking can be observed.
  function automatic logic [33:0] alu_ref(input logic [5:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] sum;
    logic [31:0] r;
    logic        z;
    logic        ov;
    sum = {1'b0, a} + {1'b0, b};
    ov  = 1'b0;
    case (c)
      6'd32, 6'd8:  begin r = sum[31:0]; ov = sum[32]; end
      6'd34:        r = a - b;
      6'd36, 6'd12: r = a & b;
      6'd37, 6'd13: r = a | b;
      6'd39:        r = ~(a | b);
      6'd14:        r = a ^ b;
      6'd42, 6'd10: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd4, 6'd5, 6'd1: r = a - b;
      default:      r = 32'hDEAD_BEEF;
    endcase
    case (c)
      6'd4:    z = (a == b);
      6'd5:    z = (a != b);
      6'd1:    z = ($signed(a) >= 0);
      6'd0:    begin z = 1'b1; ov = 1'b1; end
      default: z = (r == 32'd0);
    endcase
    return {ov, z, r};
  endfunction

  function automatic void ref_decode(input logic [31:0] instr, input logic [31:0] rs,
                                     input logic [31:0] rt, output logic [5:0] c,
                                     output logic [31:0] a, output logic [31:0] b,
                                     output logic br, output logic ill);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] imm;
    op = instr[31:26];
    fn = instr[5:0];
    imm = instr[15:0];
    c = 6'd0; a = 32'd0; b = 32'd0; br = 1'b0; ill = 1'b1;
    if (op == 6'd0 && (fn inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42})) begin
      c = fn; a = rs; b = rt; ill = 1'b0;
    end else if (op inside {6'd8, 6'd10}) begin
      c = op; a = rs; b = 32'($signed(imm)); ill = 1'b0;
    end else if (op inside {6'd12, 6'd13, 6'd14}) begin
      c = op; a = rs; b = {16'd0, imm}; ill = 1'b0;
    end else if (op inside {6'd4, 6'd5}) begin
      c = op; a = rs; b = rt; br = 1'b1; ill = 1'b0;
    end else if (op == 6'd1) begin
      c = op; a = rs; b = 32'd0; br = 1'b1; ill = 1'b0;
    end
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    alu_op_issuer #(
      .SETTLE_CYCLES  (g == 0 ? 1 : 4),
      .COUNT_RESET_VAL(g == 0 ? 16'h0000 : 16'hFFFD)
    ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid[g]),
      .req_ready       (req_ready[g]),
      .req_instr       (req_instr[g]),
      .req_rs_val      (req_rs_val[g]),
      .req_rt_val      (req_rt_val[g]),
      .alu_control     (alu_control[g]),
      .alu_a           (alu_a[g]),
      .alu_b           (alu_b[g]),
      .alu_out         (alu_out[g]),
      .alu_zero        (alu_zero[g]),
      .alu_overflow    (alu_overflow[g]),
      .rsp_valid       (rsp_valid[g]),
      .rsp_ready       (rsp_ready[g]),
      .rsp_result      (rsp_result[g]),
      .rsp_branch_taken(rsp_branch_taken[g]),
      .rsp_overflow    (rsp_overflow[g]),
      .rsp_illegal     (rsp_illegal[g]),
      .op_count        (op_count[g])
    );
    assign {alu_overflow[g], alu_zero[g], alu_out[g]} =
      alu_ref(alu_control[g], alu_a[g], alu_b[g]);
  end

  task automatic chk(input string tag, input string what, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", tag, what, act, exp);
    end
  endtask

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Entered and left at a negedge with rsp_ready low.
  task automatic run_op(input int d, input string tag, input logic [31:0] instr,
                        input logic [31:0] rs, input logic [31:0] rt, input int hold,
                        input logic [5:0] e_ctrl, input logic [31:0] e_a,
                        input logic [31:0] e_b, input logic [31:0] e_res,
                        input logic e_br, input logic e_ov, input logic e_ill);
    int n;
    int s;
    s = settle_of(d);
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, "req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d]  = 1'b1;
    req_instr[d]  = instr;
    req_rs_val[d] = rs;
    req_rt_val[d] = rt;
    @(posedge clk); #1;
    req_valid[d]  = 1'b0;
    req_instr[d]  = $urandom;
    req_rs_val[d] = $urandom;
    req_rt_val[d] = $urandom;
    chk(tag, "req_ready_busy", 32'(req_ready[d]), 32'd0);
    chk(tag, "alu_control", 32'(alu_control[d]), 32'(e_ctrl));
    chk(tag, "alu_a", alu_a[d], e_a);
    chk(tag, "alu_b", alu_b[d], e_b);
    chk(tag, "rsp_valid_issue", 32'(rsp_valid[d]), 32'd0);
    for (int i = 1; i <= s; i++) begin
      @(posedge clk); #1;
      if (i < s) begin
        chk(tag, "alu_control_hold", 32'(alu_control[d]), 32'(e_ctrl));
        chk(tag, "alu_b_hold", alu_b[d], e_b);
        chk(tag, "rsp_valid_settle", 32'(rsp_valid[d]), 32'd0);
      end
    end
    chk(tag, "rsp_valid", 32'(rsp_valid[d]), 32'd1);
    chk(tag, "alu_control_after", 32'(alu_control[d]), 32'd0);
    chk(tag, "alu_ab_after", alu_a[d] | alu_b[d], 32'd0);
    chk(tag, "rsp_result", rsp_result[d], e_res);
    chk(tag, "rsp_branch_taken", 32'(rsp_branch_taken[d]), 32'(e_br));
    chk(tag, "rsp_overflow", 32'(rsp_overflow[d]), 32'(e_ov));
    chk(tag, "rsp_illegal", 32'(rsp_illegal[d]), 32'(e_ill));
    for (int j = 0; j < hold; j++) begin
      @(posedge clk); #1;
      chk(tag, "bp_rsp_valid", 32'(rsp_valid[d]), 32'd1);
      chk(tag, "bp_rsp_result", rsp_result[d], e_res);
      chk(tag, "bp_req_ready", 32'(req_ready[d]), 32'd0);
      chk(tag, "bp_op_count", 32'(op_count[d]), 32'(exp_count[d]));
    end
    @(negedge clk);
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    exp_count[d] = exp_count[d] + 16'd1;
    chk(tag, "rsp_valid_done", 32'(rsp_valid[d]), 32'd0);
    chk(tag, "req_ready_done", 32'(req_ready[d]), 32'd1);
    chk(tag, "op_count", 32'(op_count[d]), 32'(exp_count[d]));
    chk(tag, "rsp_result_held", rsp_result[d], e_res);
    @(negedge clk);
    rsp_ready[d] = 1'b0;
  endtask

  task automatic run_model_op(input int d, input string tag, input logic [31:0] instr,
                              input logic [31:0] rs, input logic [31:0] rt, input int hold);
    logic [5:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic        br;
    logic        ill;
    logic [33:0] r;
    ref_decode(instr, rs, rt, c, a, b, br, ill);
    r = alu_ref(c, a, b);
    run_op(d, tag, instr, rs, rt, hold, c, a, b,
           ill ? 32'd0 : r[31:0], br & r[32], ill ? 1'b0 : r[33], ill);
  endtask

  task automatic check_reset_state(input int d, input string tag, input logic [15:0] e_cnt);
    chk(tag, "req_ready", 32'(req_ready[d]), 32'd1);
    chk(tag, "rsp_valid", 32'(rsp_valid[d]), 32'd0);
    chk(tag, "alu_control", 32'(alu_control[d]), 32'd0);
    chk(tag, "alu_ab", alu_a[d] | alu_b[d], 32'd0);
    chk(tag, "rsp_result", rsp_result[d], 32'd0);
    chk(tag, "rsp_flags",
        32'({rsp_branch_taken[d], rsp_overflow[d], rsp_illegal[d]}), 32'd0);
    chk(tag, "op_count", 32'(op_count[d]), 32'(e_cnt));
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    int          hold;
    logic [5:0]  ctrl;
    logic [31:0] b;
    logic [31:0] res;
    logic        br;
    logic        ov;
    logic        ill;
  } vec_t;

  vec_t vecs [14];
  logic [5:0] rand_ops [14] = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5,
                                 6'd8, 6'd10, 6'd12, 6'd13, 6'd14, 6'd63};
  logic [5:0] rand_fns [8]  = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd33, 6'd0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'h0000_0020, 32'd5,         32'd7,         0, 6'd32, 32'd7,         32'd12,        1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'h2000_FFFF, 32'd10,        32'd0,         0, 6'd8,  32'hFFFF_FFFF, 32'd9,         1'b0, 1'b1, 1'b0};
    vecs[2]  = '{32'h3000_8000, 32'hFFFF_FFFF, 32'd0,         1, 6'd12, 32'h0000_8000, 32'h0000_8000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h1000_0000, 32'd3,         32'd3,         0, 6'd4,  32'd3,         32'd0,         1'b1, 1'b0, 1'b0};
    vecs[4]  = '{32'h1400_0000, 32'd3,         32'd3,         0, 6'd5,  32'd3,         32'd0,         1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'h0400_0000, 32'd0,         32'h0000_1234, 0, 6'd1,  32'd0,         32'd0,         1'b1, 1'b0, 1'b0};
    vecs[6]  = '{32'h0800_0000, 32'd9,         32'd4,         5, 6'd0,  32'd0,         32'd0,         1'b0, 1'b0, 1'b1};
    vecs[7]  = '{32'h0000_0021, 32'd1,         32'd2,         0, 6'd0,  32'd0,         32'd0,         1'b0, 1'b0, 1'b1};
    vecs[8]  = '{32'h0000_0022, 32'd7,         32'd5,         2, 6'd34, 32'd5,         32'd2,         1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h2800_FFFF, 32'hFFFF_FFFE, 32'd0,         0, 6'd10, 32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h3800_00FF, 32'h0F0F_0F0F, 32'd0,         0, 6'd14, 32'h0000_00FF, 32'h0F0F_0FF0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h0000_0027, 32'd0,         32'hFFFF_0000, 0, 6'd39, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{32'h1400_0000, 32'd1,         32'd2,         0, 6'd5,  32'd2,         32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{32'h0400_0000, 32'h8000_0000, 32'd0,         0, 6'd1,  32'd0,         32'h8000_0000, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      req_valid[d]  = 1'b0;
      req_instr[d]  = 32'd0;
      req_rs_val[d] = 32'd0;
      req_rt_val[d] = 32'd0;
      rsp_ready[d]  = 1'b0;
    end
    exp_count[0] = 16'h0000;
    exp_count[1] = 16'hFFFD;
    #12;
    check_reset_state(0, "reset0", 16'h0000);
    check_reset_state(1, "reset1", 16'hFFFD);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      run_op(0, $sformatf("vec%0d", i), vecs[i].instr, vecs[i].rs, vecs[i].rt, vecs[i].hold,
             vecs[i].ctrl, vecs[i].ill ? 32'd0 : vecs[i].rs, vecs[i].b, vecs[i].res,
             vecs[i].br, vecs[i].ov, vecs[i].ill);
    end

    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 40; i++) begin
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        instr = $urandom;
        instr[31:26] = rand_ops[$urandom_range(0, 13)];
        instr[5:0]   = rand_fns[$urandom_range(0, 7)];
        rs = $urandom;
        if ($urandom_range(0, 3) == 0) rs = 32'($urandom_range(0, 3));
        rt = ($urandom_range(0, 2) == 0) ? rs : 32'($urandom);
        run_model_op(d, $sformatf("rnd%0d_%0d", d, i), instr, rs, rt,
                     int'($urandom_range(0, 3)));
      end
    end

    // Reset in the middle of a SETTLE=4 issue window.
    req_valid[1]  = 1'b1;
    req_instr[1]  = 32'h0000_0020;
    req_rs_val[1] = 32'd100;
    req_rt_val[1] = 32'd23;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    chk("midreset", "alu_control_before", 32'(alu_control[1]), 32'd32);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state(1, "midreset1", 16'hFFFD);
    check_reset_state(0, "midreset0", 16'h0000);
    exp_count[0] = 16'h0000;
    exp_count[1] = 16'hFFFD;
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (rsp_valid[1] !== 1'b0) seen++;
      end
      chk("midreset", "no_response", 32'(seen), 32'd0);
    end
    @(negedge clk);

    // Count wrap: three completions from 0xFFFD land on 0.
    run_op(1, "after_reset", 32'h0000_0020, 32'd100, 32'd23, 0,
           6'd32, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 1'b0);
    run_model_op(1, "wrap_a", 32'h3400_1234, 32'h0000_F000, 32'd0, 0);
    run_model_op(1, "wrap_b", 32'h0000_002A, 32'hFFFF_FFFF, 32'd1, 1);
    chk("wrap", "op_count_zero", 32'(op_count[1]), 32'd0);
    run_model_op(1, "post_wrap", 32'h1000_0000, 32'd8, 32'd8, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
